// File: rtl/memory_write_controller.sv
// memory_write_controller
//   Front end for the 4x8-bit memory system. Synchronises and debounces the
//   store push-button and the data/address switches, then turns each clean
//   press into one write: data/addr are captured, held for a setup cycle,
//   store pulses for STORE_CYCLES cycles, then one hold cycle follows.
//
// Ports
//   clk          system clock (single domain)
//   reset_n      asynchronous active-low reset
//   btn_store    raw bouncing store button
//   sw_data[7:0] raw data switches
//   sw_addr[1:0] raw address switches
//   data[7:0]    registered data to memory
//   addr[1:0]    registered address to memory
//   store        registered write strobe
//   busy         high whenever the FSM is not idle
//   write_count  completed writes, modulo 256
module memory_write_controller #(
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int DB_W            = 17,
  parameter int STORE_CYCLES    = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_store,
  input  logic [7:0] sw_data,
  input  logic [1:0] sw_addr,
  output logic [7:0] data,
  output logic [1:0] addr,
  output logic       store,
  output logic       busy,
  output logic [7:0] write_count
);

  localparam int SC_W = (STORE_CYCLES > 1) ? $clog2(STORE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES);
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(STORE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, SETUP, WRITE, HOLD, WAIT_RELEASE
  } state_e;

  // ---------------------------------------------------------------- sync
  logic [1:0] btn_sync_q;
  logic [7:0] data_s1_q, data_s2_q;
  logic [1:0] addr_s1_q, addr_s2_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      btn_sync_q <= '0;
      data_s1_q  <= '0;
      data_s2_q  <= '0;
      addr_s1_q  <= '0;
      addr_s2_q  <= '0;
    end else begin
      btn_sync_q <= {btn_sync_q[0], btn_store};
      data_s1_q  <= sw_data;
      data_s2_q  <= data_s1_q;
      addr_s1_q  <= sw_addr;
      addr_s2_q  <= addr_s1_q;
    end
  end

  // ------------------------------------------------------------ debounce
  // The counter runs only while the synced button disagrees with the
  // debounced level; any agreeing sample clears it, so a glitch must
  // persist uninterrupted before the level flips.
  logic            level_q, level_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;

  always_comb begin
    level_d  = level_q;
    db_cnt_d = '0;
    if (btn_sync_q[1] != level_q) begin
      if (db_cnt_q == DB_LAST) level_d = ~level_q;
      else                     db_cnt_d = db_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level_q  <= 1'b0;
      db_cnt_q <= '0;
    end else begin
      level_q  <= level_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  // ----------------------------------------------------------------- FSM
  state_e          state_q, state_d;
  logic [SC_W-1:0] sc_q, sc_d;
  logic [7:0]      data_q, data_d;
  logic [1:0]      addr_q, addr_d;
  logic [7:0]      wc_q, wc_d;
  logic            store_q, busy_q;

  always_comb begin
    state_d = state_q;
    sc_d    = sc_q;
    data_d  = data_q;
    addr_d  = addr_q;
    wc_d    = wc_q;
    case (state_q)
      // WAIT_RELEASE only returns here once the level is low, so a high
      // level seen in IDLE is always a fresh debounced rising edge.
      IDLE: begin
        data_d = data_s2_q;
        addr_d = addr_s2_q;
        if (level_q) state_d = SETUP;
      end
      SETUP: begin
        sc_d    = '0;
        state_d = WRITE;
      end
      WRITE: begin
        if (sc_q == SC_LAST) state_d = HOLD;
        else                 sc_d    = sc_q + 1'b1;
      end
      HOLD: begin
        wc_d    = wc_q + 8'd1;
        state_d = WAIT_RELEASE;
      end
      WAIT_RELEASE: begin
        if (!level_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // store/busy are decoded from the next state so they are true flops
  // aligned with the state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      sc_q    <= '0;
      data_q  <= '0;
      addr_q  <= '0;
      wc_q    <= '0;
      store_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sc_q    <= sc_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      wc_q    <= wc_d;
      store_q <= (state_d == WRITE);
      busy_q  <= (state_d != IDLE);
    end
  end

  assign data        = data_q;
  assign addr        = addr_q;
  assign store       = store_q;
  assign busy        = busy_q;
  assign write_count = wc_q;

endmodule

// File: tb/tb_memory_write_controller.sv
module tb_memory_write_controller;
  localparam int D = 4;
  localparam int S = 2;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       btn_store;
  logic [7:0] sw_data;
  logic [1:0] sw_addr;
  logic [7:0] data;
  logic [1:0] addr;
  logic       store;
  logic       busy;
  logic [7:0] write_count;

  memory_write_controller #(
    .DEBOUNCE_CYCLES(D),
    .DB_W           (3),
    .STORE_CYCLES   (S)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .btn_store  (btn_store),
    .sw_data    (sw_data),
    .sw_addr    (sw_addr),
    .data       (data),
    .addr       (addr),
    .store      (store),
    .busy       (busy),
    .write_count(write_count)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int         n_pulses = 0;
  logic [7:0] p_d  [0:1023];
  logic [1:0] p_a  [0:1023];
  int         p_w  [0:1023];
  logic       p_ok [0:1023];
  logic       prev_store = 1'b0;
  logic [7:0] prev_data  = '0;
  logic [1:0] prev_addr  = '0;
  logic [7:0] cur_d = '0;
  logic [1:0] cur_a = '0;
  int         cur_w = 0;
  logic       cur_ok = 1'b0;

  always @(negedge clk) begin
    prev_store <= store;
    prev_data  <= data;
    prev_addr  <= addr;
    if (store && !prev_store) begin
      cur_d  <= data;
      cur_a  <= addr;
      cur_w  <= 1;
      cur_ok <= (data == prev_data) && (addr == prev_addr);
    end else if (store && prev_store) begin
      cur_w <= cur_w + 1;
      if (data != cur_d || addr != cur_a) cur_ok <= 1'b0;
    end else if (!store && prev_store) begin
      p_d[n_pulses[9:0]]  <= cur_d;
      p_a[n_pulses[9:0]]  <= cur_a;
      p_w[n_pulses[9:0]]  <= cur_w;
      p_ok[n_pulses[9:0]] <= cur_ok && (data == cur_d) && (addr == cur_a);
      n_pulses            <= n_pulses + 1;
    end
  end

  int checks = 0;
  int errors = 0;
  int rd     = 0;
  int exp_wc = 0;

  task automatic fail(input string tag);
    errors++;
    $error("FAIL %s at %0t", tag, $time);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy !== 1'b0) fail("idle timeout");
  endtask

  task automatic check_pulse(input logic [7:0] d, input logic [1:0] a);
    checks++;
    if (n_pulses !== rd + 1) fail("pulse count");
    if (n_pulses > rd) begin
      checks++;
      if (p_d[rd[9:0]] !== d) fail("pulse data");
      checks++;
      if (p_a[rd[9:0]] !== a) fail("pulse addr");
      checks++;
      if (p_w[rd[9:0]] !== S) fail("pulse width");
      checks++;
      if (p_ok[rd[9:0]] !== 1'b1) fail("pulse stable");
    end
    rd = n_pulses;
    exp_wc++;
    checks++;
    if (write_count !== 8'(exp_wc)) fail("write_count");
  endtask

  task automatic press(input logic [7:0] d, input logic [1:0] a,
                       input int hold, input int glitches, input bit mid);
    @(negedge clk);
    sw_data = d;
    sw_addr = a;
    repeat (3) @(negedge clk);
    for (int g = 0; g < glitches; g++) begin
      btn_store = 1'b1;
      repeat ($urandom_range(1, 3)) @(negedge clk);
      btn_store = 1'b0;
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    btn_store = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (mid && i == 12) begin
        sw_data = 8'($urandom);
        sw_addr = 2'($urandom);
      end
    end
    btn_store = 1'b0;
    wait_idle();
    repeat (2) @(negedge clk);
    check_pulse(d, a);
  endtask

  initial begin
    logic flag;
    logic [7:0] rd_d;
    logic [1:0] rd_a;

    reset_n   = 1'b0;
    btn_store = 1'b0;
    sw_data   = '0;
    sw_addr   = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (data !== 8'h00) fail("reset data");
    checks++;
    if (addr !== 2'd0) fail("reset addr");
    checks++;
    if (store !== 1'b0) fail("reset store");
    checks++;
    if (busy !== 1'b0) fail("reset busy");
    checks++;
    if (write_count !== 8'h00) fail("reset write_count");
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (busy !== 1'b0) fail("post-reset busy");

    btn_store = 1'b1;
    sw_data   = 8'hA5;
    sw_addr   = 2'd2;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if (store !== (k == 8 || k == 9)) fail("store timing");
      checks++;
      if (busy !== (k >= 7)) fail("busy timing");
      if (k >= 7 && k <= 10) begin
        checks++;
        if (data !== 8'hA5) fail("capture data");
        checks++;
        if (addr !== 2'd2) fail("capture addr");
      end
      if (k == 8) begin
        sw_data = 8'h3C;
        sw_addr = 2'd1;
      end
      if (k == 11) begin
        checks++;
        if (write_count !== 8'd1) fail("first count");
      end
    end
    flag = 1'b1;
    for (int k = 12; k < 50; k++) begin
      @(posedge clk);
      #1;
      if (busy !== 1'b1 || data !== 8'hA5 || addr !== 2'd2) flag = 1'b0;
    end
    checks++;
    if (flag !== 1'b1) fail("long hold busy/held values");
    @(negedge clk);
    btn_store = 1'b0;
    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (data !== 8'h3C) fail("idle tracks data");
    checks++;
    if (addr !== 2'd1) fail("idle tracks addr");
    @(negedge clk);
    check_pulse(8'hA5, 2'd2);

    press(8'h5A, 2'd3, 20, 4, 1'b0);

    flag = 1'b0;
    for (int g = 0; g < 6; g++) begin
      btn_store = 1'b1;
      repeat (3) @(negedge clk);
      if (busy !== 1'b0) flag = 1'b1;
      btn_store = 1'b0;
      @(negedge clk);
      if (busy !== 1'b0) flag = 1'b1;
    end
    repeat (15) begin
      @(negedge clk);
      if (busy !== 1'b0) flag = 1'b1;
    end
    checks++;
    if (flag !== 1'b0) fail("glitch busy");
    checks++;
    if (n_pulses !== rd) fail("glitch no pulse");
    checks++;
    if (write_count !== 8'(exp_wc)) fail("glitch count");

    press(8'h11, 2'd0, 16, 0, 1'b0);
    press(8'h22, 2'd1, 16, 0, 1'b0);
    press(8'h33, 2'd2, 16, 0, 1'b0);
    press(8'h44, 2'd3, 16, 0, 1'b0);

    for (int i = 0; i < 20; i++) begin
      rd_d = 8'($urandom);
      rd_a = 2'($urandom);
      press(rd_d, rd_a, $urandom_range(14, 60), $urandom_range(0, 3),
            1'($urandom));
    end

    @(negedge clk);
    sw_data   = 8'hC3;
    sw_addr   = 2'd1;
    btn_store = 1'b1;
    begin
      int n = 0;
      while (store !== 1'b1 && n < 50) begin
        @(posedge clk);
        #1;
        n++;
      end
    end
    checks++;
    if (store !== 1'b1) fail("reach WRITE");
    reset_n = 1'b0;
    #1;
    checks++;
    if (store !== 1'b0) fail("mid reset store");
    checks++;
    if (busy !== 1'b0) fail("mid reset busy");
    checks++;
    if (data !== 8'h00) fail("mid reset data");
    checks++;
    if (addr !== 2'd0) fail("mid reset addr");
    checks++;
    if (write_count !== 8'h00) fail("mid reset write_count");
    btn_store = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    exp_wc  = 0;
    rd      = n_pulses;
    repeat (30) @(negedge clk);
    checks++;
    if (n_pulses !== rd) fail("no spurious write");
    checks++;
    if (busy !== 1'b0) fail("no spurious busy");
    checks++;
    if (write_count !== 8'h00) fail("count after reset");

    for (int i = 0; i < 256; i++) press(8'(i), 2'(i), 14, 0, 1'b0);
    checks++;
    if (write_count !== 8'h00) fail("wrap to zero");

    @(negedge clk);
    sw_data   = 8'h96;
    sw_addr   = 2'd3;
    btn_store = 1'b1;
    reset_n   = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    exp_wc  = 0;
    repeat (20) @(negedge clk);
    btn_store = 1'b0;
    wait_idle();
    repeat (2) @(negedge clk);
    check_pulse(8'h96, 2'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/memory_write_controller.md
# memory_write_controller

Synchronous front end for the 4×8-bit memory system. Takes the raw store push-button and data/address switches, synchronises and debounces them, and converts each clean button press into exactly one well-formed write: captured data and address held stable around a fixed-width store pulse. It sits directly upstream of the memory system, driving its `data`, `addr` and `store` inputs.

## Interface
- `DEBOUNCE_CYCLES`, default 100000: consecutive stable cycles required before the debounced button level changes (1 ms at 100 MHz).
- `DB_W`, default 17: debounce counter width; must satisfy 2^DB_W > DEBOUNCE_CYCLES.
- `STORE_CYCLES`, default 2: cycles `store` is held high per write, ≥1.

Ports:
- `clk`  in  1  system clock; only clock domain.
- `reset_n`  in  1  asynchronous, active-low reset.
- `btn_store`  in  1  raw, bouncing, asynchronous store button.
- `sw_data`  in  8  raw data switches.
- `sw_addr`  in  2  raw address switches.
- `data`  out  8  registered data to memory system.
- `addr`  out  2  registered address to memory system (write and read-select).
- `store`  out  1  registered write strobe to memory system.
- `busy`  out  1  high whenever state ≠ IDLE.
- `write_count`  out  8  completed writes, modulo 256.

## Operation
- **Reset (async, `reset_n`=0):** all sync flops, debounce counter, debounced level = 0; state = IDLE; `data`=0, `addr`=0, `store`=0, `busy`=0, `write_count`=0. `store` falls immediately on assertion, mid-write included; no partial write is resumed.
- **Synchronisation:** `btn_store`, `sw_data`, `sw_addr` each pass through a 2-flop synchroniser.
- **Debounce:** counter clears whenever synced button equals the debounced level. Otherwise it increments; on reaching `DEBOUNCE_CYCLES` the level toggles and the counter clears. A glitch shorter than `DEBOUNCE_CYCLES` produces no level change.
- **FSM:**
  - **IDLE:** `store`=0; `data`/`addr` track the synced switches so the memory read path shows the selected byte. On a debounced rising edge, capture the synced `sw_data`/`sw_addr` into the output registers, then go to SETUP.
  - **SETUP:** 1 cycle, `store`=0, captured values driven; go to WRITE.
  - **WRITE:** `store`=1 for exactly `STORE_CYCLES` cycles, captured values held; go to HOLD.
  - **HOLD:** 1 cycle, `store`=0, captured values held; `write_count` increments (255 wraps to 0); go to WAIT_RELEASE.
  - **WAIT_RELEASE:** captured values held; go to IDLE when the debounced level is 0.
- Switch changes during SETUP, WRITE, HOLD or WAIT_RELEASE are ignored.
- One press gives exactly one write, however long the button is held.
- A button already held when reset is released counts as a press once debounced.

## Timing
- All outputs are registered; no combinational path from any input to any output.
- For a clean input first sampled high at edge 0: debounced level rises at edge `DEBOUNCE_CYCLES`+2, SETUP is entered at +3, and `store` rises at edge `DEBOUNCE_CYCLES`+4.
- `addr`/`data` are stable ≥1 cycle before `store` rises and ≥1 cycle after it falls.
- Minimum spacing between write starts: press-to-release debounce plus the next press debounce, never less than 2·`DEBOUNCE_CYCLES`.
- In IDLE, `addr`/`data` follow switch changes with 3-cycle latency (2 sync + output register).

## Test plan
- **Reset:** assert `reset_n`=0 mid-WRITE with `store`=1 → `store`, `busy`, `data`, `addr`, `write_count` all 0 in the same cycle; after release, state is IDLE and there is no spurious write.
- **Clean press** (`DEBOUNCE_CYCLES`=4, `STORE_CYCLES`=2): `sw_data`=8'hA5, `sw_addr`=2'd2, button high → `store` high on edges 8–9 with `data`=A5, `addr`=2 from edge 7 through edge 10; `write_count`=1.
- **Bounce:** 3-cycle high glitches separated by 1-cycle lows, then steady high → exactly one write; glitch-only stimulus → no write, `busy` stays 0.
- **Switch change mid-write:** change `sw_data` to 8'h3C and `sw_addr` to 2'd1 during WRITE → `data`/`addr` stay A5/2 until IDLE, then show 3C/1 three cycles later.
- **Long hold and wrap:** hold the button for 50 cycles → single write, `busy` high until the debounced release. Issue 256 presses → `write_count` returns to 0.
- **All addresses:** write 11, 22, 33, 44 to addresses 0–3 → each `store` pulse carries the matching `addr`/`data` pair.
